// File: rtl/neuron_pkg.sv
// neuron_pkg -- shared types and constants for the neuron datapath blocks.
//   acc_state_e             : potential_accumulator timestep state encoding
//   FP32_ZERO / FP32_QNAN   : IEEE-754 single-precision constants
//   DEFAULT_*               : default firing threshold, post-spike potential,
//                             refractory length
package neuron_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_COMPARE,
    ST_OUTPUT
  } acc_state_e;

  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

  localparam logic [31:0] DEFAULT_THRESHOLD       = 32'h41F0_0000;  // 30.0
  localparam logic [31:0] DEFAULT_RESET_POTENTIAL = FP32_ZERO;
  localparam int unsigned DEFAULT_REFRACT_STEPS   = 2;

  localparam logic [7:0] WT_COUNT_MAX = 8'hFF;

endpackage

// File: rtl/Addition_Subtraction.sv
// Addition_Subtraction -- combinational IEEE-754 single-precision add/subtract,
// round-to-nearest-even, subnormals supported.
//   a_i, b_i    : fp32 operands
//   sub_i       : 1 computes a_i - b_i, 0 computes a_i + b_i
//   result_o    : fp32 result (NaN results are the canonical quiet NaN)
//   exception_o : result is Inf or NaN (invalid operation, overflow, Inf input)
module Addition_Subtraction
  import neuron_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        sub_i,
  output logic [31:0] result_o,
  output logic        exception_o
);

  logic [31:0] b_eff, big, sml;
  logic [7:0]  shamt;
  logic [26:0] m_big, m_sml, m_shr;   // 24-bit significand + guard/round/sticky
  logic [27:0] m_sum;
  logic [24:0] m_rnd;
  logic        sticky, round_up;
  int          e;

  always_comb begin
    b_eff = {b_i[31] ^ sub_i, b_i[30:0]};
    // Order by magnitude so the alignment shift is always applied to the smaller operand.
    if (a_i[30:0] >= b_eff[30:0]) begin
      big = a_i;
      sml = b_eff;
    end else begin
      big = b_eff;
      sml = a_i;
    end

    m_big = {big[30:23] != 8'd0, big[22:0], 3'b000};
    m_sml = {sml[30:23] != 8'd0, sml[22:0], 3'b000};
    // Subnormals share the exponent of the smallest normal.
    shamt = ((big[30:23] == 8'd0) ? 8'd1 : big[30:23])
          - ((sml[30:23] == 8'd0) ? 8'd1 : sml[30:23]);
    m_shr  = m_sml >> shamt;
    sticky = (m_shr << shamt) != m_sml;
    m_shr[0] = m_shr[0] | sticky;
    e = (big[30:23] == 8'd0) ? 1 : int'(big[30:23]);

    if (big[31] == sml[31]) m_sum = {1'b0, m_big} + {1'b0, m_shr};
    else                    m_sum = {1'b0, m_big} - {1'b0, m_shr};

    if (m_sum[27]) begin
      m_sum = {1'b0, m_sum[27:2], m_sum[1] | m_sum[0]};
      e     = e + 1;
    end
    // Left-normalise after cancellation, stopping at the subnormal exponent.
    for (int i = 0; i < 26; i++) begin
      if (!m_sum[26] && e > 1 && m_sum != 28'd0) begin
        m_sum = m_sum << 1;
        e     = e - 1;
      end
    end

    round_up = m_sum[2] & (m_sum[1] | m_sum[0] | m_sum[3]);
    m_rnd    = {1'b0, m_sum[26:3]} + {24'd0, round_up};
    if (m_rnd[24]) begin
      m_rnd = m_rnd >> 1;
      e     = e + 1;
    end

    exception_o = 1'b0;
    result_o    = {big[31], (m_rnd[23] ? e[7:0] : 8'd0), m_rnd[22:0]};
    if (big[30:0] > 31'h7F80_0000) begin
      result_o    = FP32_QNAN;
      exception_o = 1'b1;
    end else if (big[30:0] == 31'h7F80_0000) begin
      result_o    = (sml[30:0] == 31'h7F80_0000 && sml[31] != big[31]) ? FP32_QNAN : big;
      exception_o = 1'b1;
    end else if (m_sum == 28'd0) begin
      // Exact zero: -0 only when both inputs are negative.
      result_o = {big[31] & sml[31], 31'd0};
    end else if (e >= 255) begin
      result_o    = {big[31], 8'hFF, 23'd0};
      exception_o = 1'b1;
    end
  end

endmodule

// File: rtl/fp32_compare_ge.sv
// fp32_compare_ge -- combinational a_i >= b_i on fp32 values.
//   a_i, b_i : fp32 operands
//   ge_o     : 1 when a_i >= b_i; 0 if either operand is NaN; -0 equals +0
module fp32_compare_ge (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        ge_o
);

  logic a_nan, b_nan;

  assign a_nan = (a_i[30:23] == 8'hFF) && (a_i[22:0] != 23'd0);
  assign b_nan = (b_i[30:23] == 8'hFF) && (b_i[22:0] != 23'd0);

  always_comb begin
    if (a_nan || b_nan)                              ge_o = 1'b0;
    else if (a_i[30:0] == 31'd0 && b_i[30:0] == 31'd0) ge_o = 1'b1;
    else if (a_i[31] != b_i[31])                     ge_o = !a_i[31];
    else if (!a_i[31])                               ge_o = a_i[30:0] >= b_i[30:0];
    else                                             ge_o = a_i[30:0] <= b_i[30:0];
  end

endmodule

// File: rtl/potential_accumulator.sv
// potential_accumulator -- one neuron's per-timestep membrane potential
// accumulation and threshold decision.
//   CLK, RST_N               : clock, asynchronous active-low reset
//   dec_valid/ready/potential: decayed potential from the decay stage
//   w_valid/ready/data       : fp32 synaptic weight stream
//   ts_end                   : timestep-end pulse
//   out_valid/ready          : result handshake back to the decay stage
//   out_potential, spike     : new potential and fire decision
//   wt_count                 : weights added this timestep (saturating)
//   acc_exc, ts_overrun      : sticky flags, cleared by clr_flags
// Optional feature macro: REFRACTORY_EN (post-spike input suppression).
module potential_accumulator
  import neuron_pkg::*;
#(
  parameter logic [31:0] THRESHOLD       = DEFAULT_THRESHOLD,
  parameter logic [31:0] RESET_POTENTIAL = DEFAULT_RESET_POTENTIAL
`ifdef REFRACTORY_EN
  ,
  parameter int unsigned REFRACT_STEPS   = DEFAULT_REFRACT_STEPS
`endif
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic [31:0] dec_potential,
  input  logic        w_valid,
  output logic        w_ready,
  input  logic [31:0] w_data,
  input  logic        ts_end,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_potential,
  output logic        spike,
  output logic [7:0]  wt_count,
  output logic        acc_exc,
  output logic        ts_overrun,
  input  logic        clr_flags
);

  acc_state_e  state_q, state_d;
  logic [31:0] acc_q, acc_d, pot_q, pot_d, sum;
  logic [7:0]  cnt_q, cnt_d;
  logic        spike_q, spike_d, exc_q, exc_d, ovr_q, ovr_d;
  logic        live_q;      // holds dec_ready low until the first edge after reset release
  logic        sum_exc, ge, add_en, add_fire;

  Addition_Subtraction u_add (
    .a_i        (acc_q),
    .b_i        (w_data),
    .sub_i      (1'b0),
    .result_o   (sum),
    .exception_o(sum_exc)
  );

  fp32_compare_ge u_cmp (
    .a_i (acc_q),
    .b_i (THRESHOLD),
    .ge_o(ge)
  );

`ifdef REFRACTORY_EN
  logic [7:0] refr_q, refr_d;

  // Weights are still handshaken during refractory steps, just not summed.
  assign add_en = (refr_q == 8'd0);

  always_comb begin
    refr_d = refr_q;
    if (state_q == ST_OUTPUT && out_ready) begin
      if (spike_q)               refr_d = 8'(REFRACT_STEPS);
      else if (refr_q != 8'd0)   refr_d = refr_q - 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) refr_q <= 8'd0;
    else        refr_q <= refr_d;
  end
`else
  assign add_en = 1'b1;
`endif

  assign add_fire      = (state_q == ST_ACCUM) && w_valid && add_en;
  assign dec_ready     = (state_q == ST_IDLE) && live_q;
  assign w_ready       = (state_q == ST_ACCUM);
  assign out_valid     = (state_q == ST_OUTPUT);
  assign out_potential = pot_q;
  assign spike         = spike_q;
  assign wt_count      = cnt_q;
  assign acc_exc       = exc_q;
  assign ts_overrun    = ovr_q;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    pot_d   = pot_q;
    spike_d = spike_q;
    unique case (state_q)
      ST_IDLE: begin
        if (dec_valid && dec_ready) begin
          acc_d   = dec_potential;
          cnt_d   = 8'd0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        // A weight in the ts_end cycle still lands in acc before the compare.
        if (add_fire) begin
          acc_d = sum;
          if (cnt_q != WT_COUNT_MAX) cnt_d = cnt_q + 8'd1;
        end
        if (ts_end) state_d = ST_COMPARE;
      end
      ST_COMPARE: begin
        spike_d = ge;
        pot_d   = ge ? RESET_POTENTIAL : acc_q;
        state_d = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Clear wins over a same-cycle set.
  assign exc_d = clr_flags ? 1'b0 : (exc_q | (add_fire & sum_exc));
  assign ovr_d = clr_flags ? 1'b0 : (ovr_q | (ts_end & (state_q != ST_ACCUM)));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      acc_q   <= FP32_ZERO;
      cnt_q   <= 8'd0;
      pot_q   <= FP32_ZERO;
      spike_q <= 1'b0;
      exc_q   <= 1'b0;
      ovr_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      pot_q   <= pot_d;
      spike_q <= spike_d;
      exc_q   <= exc_d;
      ovr_q   <= ovr_d;
      live_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_potential_accumulator.sv
// tb_potential_accumulator -- self-checking bench for potential_accumulator.
// Expected results come from an integer-arithmetic neuron model (exact for
// the integer-valued fp32 operands used) plus hand-derived fp32 constants.
module tb_potential_accumulator;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        dec_valid = 1'b0, dec_ready;
  logic [31:0] dec_potential = '0;
  logic        w_valid = 1'b0, w_ready;
  logic [31:0] w_data = '0;
  logic        ts_end = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_potential;
  logic        spike;
  logic [7:0]  wt_count;
  logic        acc_exc, ts_overrun;
  logic        clr_flags = 1'b0;

  potential_accumulator dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .dec_valid    (dec_valid),
    .dec_ready    (dec_ready),
    .dec_potential(dec_potential),
    .w_valid      (w_valid),
    .w_ready      (w_ready),
    .w_data       (w_data),
    .ts_end       (ts_end),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_potential(out_potential),
    .spike        (spike),
    .wt_count     (wt_count),
    .acc_exc      (acc_exc),
    .ts_overrun   (ts_overrun),
    .clr_flags    (clr_flags)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pot;
    logic        spk;
    logic [7:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   model_refr = 0;   // timesteps of suppression still owed after a spike

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] int_to_fp32(input int v);
    int          m, p;
    logic [31:0] r;
    if (v == 0) return 32'h0;
    m = (v < 0) ? -v : v;
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + p);
    r[22:0]  = 23'((m << (23 - p)) & 32'h7F_FFFF);
    return r;
  endfunction

  // Monitor: every output handshake is matched against the scoreboard.
  always @(negedge CLK) begin
    exp_t e;
    if (RST_N && out_valid && out_ready) begin
      check("scoreboard_has_entry", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_potential", out_potential, e.pot);
        check("spike", spike, e.spk);
        check("wt_count", wt_count, e.cnt);
      end
    end
  end

  task automatic send_dec(input logic [31:0] p);
    int n = 0;
    dec_valid     = 1'b1;
    dec_potential = p;
    while (!dec_ready && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    check("dec_ready_wait", dec_ready, 1);
    @(posedge CLK); #1;
    dec_valid = 1'b0;
  endtask

  task automatic run_step(input logic [31:0] dec, input logic [31:0] w[$], input bit ts_last,
                          input int stall, input logic [31:0] e_pot, input bit e_spk, input int e_cnt);
    exp_t e;
    send_dec(dec);
    check("w_ready_after_dec", w_ready, 1);
    foreach (w[i]) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge CLK); #1;
      end
      w_valid = 1'b1;
      w_data  = w[i];
      if (ts_last && i == w.size() - 1) ts_end = 1'b1;
      @(posedge CLK); #1;
      w_valid = 1'b0;
    end
    if (!(ts_last && w.size() > 0)) begin
      ts_end = 1'b1;
      @(posedge CLK); #1;
    end
    ts_end = 1'b0;
    e.pot = e_pot;
    e.spk = e_spk;
    e.cnt = 8'(e_cnt);
    exp_q.push_back(e);
`ifdef REFRACTORY_EN
    if (e_spk) model_refr = 2;
    else if (model_refr > 0) model_refr--;
`endif
    check("out_valid_n_plus_1", out_valid, 0);
    @(posedge CLK); #1;
    check("out_valid_n_plus_2", out_valid, 1);
    for (int s = 0; s < stall; s++) begin
      check("stall_potential", out_potential, e_pot);
      check("stall_spike", spike, e_spk);
      check("stall_w_ready", w_ready, 0);
      check("stall_dec_ready", dec_ready, 0);
      @(posedge CLK); #1;
      check("stall_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_int(input int dec, input int wi[$], input bit ts_last, input int stall);
    int          sum = dec;
    int          cnt = 0;
    logic [31:0] wb[$];
    foreach (wi[i]) begin
      wb.push_back(int_to_fp32(wi[i]));
      if (model_refr == 0) begin
        sum += wi[i];
        cnt++;
      end
    end
    if (cnt > 255) cnt = 255;
    run_step(int_to_fp32(dec), wb, ts_last, stall,
             (sum >= 30) ? 32'h0 : int_to_fp32(sum), sum >= 30, cnt);
  endtask

  task automatic drain_refractory();
    int none[$];
    while (model_refr != 0) run_int(0, none, 1'b0, 0);
  endtask

  initial begin
    logic [31:0] wq[$];
    int          wi[$];
    #2;
    check("reset_dec_ready", dec_ready, 0);
    check("reset_w_ready", w_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_potential", out_potential, 0);
    check("reset_spike", spike, 0);
    check("reset_wt_count", wt_count, 0);
    check("reset_flags", {acc_exc, ts_overrun}, 0);
    #10 RST_N = 1'b1;                 // released mid-cycle (t=12)
    #1 check("dec_ready_before_edge", dec_ready, 0);
    @(posedge CLK); #1;
    check("dec_ready_first_cycle", dec_ready, 1);

    // 20 + 10 = 30 reaches the threshold.
    wq.delete(); wq.push_back(32'h4120_0000);
    run_step(32'h41A0_0000, wq, 1'b0, 0, 32'h0000_0000, 1'b1, 1);
    drain_refractory();
    // 20 + 1 + 2 = 23 stays below, held in OUTPUT for five stall cycles.
    wq.delete(); wq.push_back(32'h3F80_0000); wq.push_back(32'h4000_0000);
    run_step(32'h41A0_0000, wq, 1'b0, 5, 32'h41B8_0000, 1'b0, 2);
    // 29 + 1 with the weight in the ts_end cycle.
    wq.delete(); wq.push_back(32'h3F80_0000);
    run_step(32'h41E8_0000, wq, 1'b1, 0, 32'h0000_0000, 1'b1, 1);
    drain_refractory();
    // Rounding: exact half ulp ties to even, just above half rounds up.
    wq.delete(); wq.push_back(32'h3380_0000);
    run_step(32'h3F80_0000, wq, 1'b0, 0, 32'h3F80_0000, 1'b0, 1);
    wq.delete(); wq.push_back(32'h3380_0001);
    run_step(32'h3F80_0000, wq, 1'b0, 1, 32'h3F80_0001, 1'b0, 1);
    // NaN potential passes through without firing.
    wq.delete();
    run_step(32'h7FC0_0000, wq, 1'b0, 0, 32'h7FC0_0000, 1'b0, 0);
    // Saturation of the weight counter.
    wq.delete();
    for (int i = 0; i < 260; i++) wq.push_back(32'h0);
    run_step(32'h0, wq, 1'b0, 0, 32'h0, 1'b0, 255);

    // ts_end in IDLE is ignored and flagged.
    ts_end = 1'b1;
    @(posedge CLK); #1;
    ts_end = 1'b0;
    check("ts_overrun_set", ts_overrun, 1);
    check("idle_after_overrun", dec_ready, 1);

    // Asynchronous reset mid-ACCUM.
    send_dec(int_to_fp32(5));
    w_valid = 1'b1; w_data = int_to_fp32(3);
    @(posedge CLK); #1;
    w_valid = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    check("rst_w_ready", w_ready, 0);
    check("rst_dec_ready", dec_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_wt_count", wt_count, 0);
    check("rst_out_potential", out_potential, 0);
    check("rst_ts_overrun", ts_overrun, 0);
    model_refr = 0;
    @(posedge CLK); #3 RST_N = 1'b1;
    @(posedge CLK); #1;
    wq.delete();
    run_step(32'h3F80_0000, wq, 1'b0, 0, 32'h3F80_0000, 1'b0, 0);

    // Overflow to +Inf raises acc_exc; Inf fires.
    wq.delete(); wq.push_back(32'h7F7F_FFFF);
    run_step(32'h7F7F_FFFF, wq, 1'b0, 0, 32'h0000_0000, 1'b1, 1);
    check("acc_exc_set", acc_exc, 1);
    clr_flags = 1'b1;
    ts_end    = 1'b1;
    @(posedge CLK); #1;
    clr_flags = 1'b0;
    ts_end    = 1'b0;
    check("clr_acc_exc", acc_exc, 0);
    check("clr_beats_overrun", ts_overrun, 0);
    drain_refractory();

`ifdef REFRACTORY_EN
    wi.delete(); wi.push_back(10);
    run_int(20, wi, 1'b0, 0);
    wi.delete(); wi.push_back(1); wi.push_back(2);
    run_int(5, wi, 1'b0, 0);
    run_int(5, wi, 1'b0, 0);
    run_int(5, wi, 1'b0, 0);
`endif

    // Randomized timesteps, including cancellation and negative potentials.
    for (int t = 0; t < 40; t++) begin
      int nw = $urandom_range(0, 6);
      wi.delete();
      for (int k = 0; k < nw; k++) wi.push_back(int'($urandom_range(0, 20)) - 8);
      run_int(int'($urandom_range(0, 60)) - 20, wi, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge CLK);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/potential_accumulator.md
# potential_accumulator

Accumulates weighted synaptic inputs onto a neuron's membrane potential within one timestep, then produces a threshold decision. The potential decay stage sends each decayed potential here. This block adds the spike-weight stream to it using the team's IEEE-754 single-precision adder. At timestep end it fires a spike and returns the new potential to the decay stage, which is the other end of the decay stage's input interface. It serves one neuron and is instantiated once per neuron in the accelerator.

## Interface
- THRESHOLD, 32'h41F00000 (30.0): fp32 firing threshold.
- RESET_POTENTIAL, 32'h00000000: fp32 potential returned after a spike.
- REFRACT_STEPS, 2: timesteps of input suppression after a spike (only with REFRACTORY_EN).

Ports:
- CLK  in  1  clock. One clock domain only.
- RST_N  in  1  reset. Asynchronous, active-low.
- dec_valid  in  1  a decayed potential is offered.
- dec_ready  out  1  block accepts the decayed potential.
- dec_potential  in  32  decayed fp32 potential.
- w_valid  in  1  a synaptic weight is offered.
- w_ready  out  1  block accepts the weight.
- w_data  in  32  fp32 weight.
- ts_end  in  1  single-cycle timestep-end pulse.
- out_valid  out  1  result is valid.
- out_ready  in  1  downstream (decay stage) accepts the result.
- out_potential  out  32  new fp32 potential.
- spike  out  1  the neuron fired; qualified by out_valid.
- wt_count  out  8  weights added this timestep; saturates at 255.
- acc_exc  out  1  sticky flag: the adder raised an exception.
- ts_overrun  out  1  sticky flag: ts_end arrived outside ACCUM.
- clr_flags  in  1  synchronous clear of acc_exc and ts_overrun.

## Operation
- State machine:
  - IDLE: dec_ready=1. On dec_valid, acc←dec_potential, wt_count←0, go to ACCUM.
  - ACCUM: w_ready=1. Each w_valid&&w_ready does acc←acc+w_data and increments wt_count. On ts_end, go to COMPARE.
  - COMPARE: spike←(acc ≥ THRESHOLD). out_potential←spike ? RESET_POTENTIAL : acc. Go to OUTPUT.
  - OUTPUT: out_valid=1. On out_ready, go to IDLE.
- ts_end and an accepted weight in the same cycle: the weight is included in acc.
- ts_end outside ACCUM is ignored and sets ts_overrun.
- Adder exception on any accumulation sets acc_exc. The exceptional result is still stored.
- Compare rules:
  - Sign-magnitude fp32 ordering.
  - −0 equals +0.
  - Any NaN operand gives spike=0, and out_potential=acc (the NaN) is passed through.
- clr_flags has priority over a same-cycle flag set.

## Timing
- Reset values: state IDLE, acc=0, all outputs 0 (dec_ready becomes 1 in the first cycle after reset release).
- Decay handshake to first weight acceptance: 1 cycle.
- Throughput: 1 weight per cycle.
- ts_end sampled in cycle N: out_valid in cycle N+2.
- Output stalls: out_potential and spike stay stable while out_valid && !out_ready. dec_ready=0 and w_ready=0 during the stall.
- RST_N asserted mid-timestep discards acc and returns to IDLE immediately. No output is produced.

## Configuration
- REFRACTORY_EN defined:
  - A spike loads refr_cnt←REFRACT_STEPS.
  - While refr_cnt≠0, weights are still accepted (w_ready=1) but not added, and wt_count does not increment.
  - refr_cnt decrements on each output handshake that does not spike.
  - Reset value of refr_cnt is 0.
- REFRACTORY_EN undefined: no counter exists and REFRACT_STEPS is unused.

## Structure
- Shared package `neuron_pkg`:
  - State encoding enum.
  - FP32 constants: FP32_ZERO, FP32_QNAN.
  - Default threshold and reset potential.
- Adder: instantiate the existing Addition_Subtraction with the subtract input tied 0.
- Sub-module: fp32_compare_ge, a combinational ≥ comparator implementing the NaN and ±0 rules above.

## Test plan
- dec=41A00000 (20.0), one weight 41200000 (10.0), ts_end → spike=1, out_potential=00000000, wt_count=1.
- dec=41A00000, weights 3F800000 and 40000000 → out_potential=41B80000 (23.0), spike=0, wt_count=2.
- dec=41E80000 (29.0); weight 3F800000 arrives in the same cycle as ts_end → 30.0 ≥ threshold, spike=1, out_valid exactly 2 cycles after ts_end.
- out_ready held 0 for 5 cycles in OUTPUT → outputs stable, w_ready=0, dec_ready=0; completes on the 6th cycle.
- RST_N pulsed low mid-ACCUM → all outputs 0 and state IDLE asynchronously. A subsequent dec=3F800000 with no weights → out_potential=3F800000.
- dec=7FC00000 (NaN) → spike=0, out_potential=7FC00000. With REFRACTORY_EN: after a spike, the next 2 timesteps ignore weights (wt_count=0); the third timestep accumulates normally.
